// File: rtl/instr_fetch_unit_pkg.sv
// Shared types for the instruction fetch unit: fetch FSM states, prefetch entry layout.
// Widths here track the default instr_fetch_unit parameters.
package instr_fetch_unit_pkg;
   localparam int IFU_ADDR_W = 20;
   localparam int IFU_STEP   = 4;
   localparam int STEP_SHIFT = $clog2(IFU_STEP);
   localparam int IFU_INSTR_W = IFU_STEP * 8;

   typedef enum logic {IDLE, RUN} fetch_state_t;

   typedef struct packed {
      logic                   misalign;
      logic [IFU_ADDR_W-1:0]  pc;
      logic [IFU_INSTR_W-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous prefetch FIFO with flush; head entry is read straight from storage registers.
module fetch_fifo
   import instr_fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  fetch_entry_t             din,
   input  logic                     pop,
   input  logic                     flush,
   output fetch_entry_t             dout,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t   store [DEPTH];
   logic [AW-1:0]  wr_ptr, rd_ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) store[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            store[wr_ptr] <= din;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign dout = store[rd_ptr];
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues word pcs to program memory, captures returned words into a prefetch FIFO.
// Build option FETCH_MISALIGN_TRAP_EN turns misaligned redirects into a single trap entry.
module instr_fetch_unit
   import instr_fetch_unit_pkg::*;
#(
   parameter int INSTR_ADDR_WIDTH = IFU_ADDR_W,
   parameter int STEP             = IFU_STEP,
   parameter int FIFO_DEPTH       = 2,
   parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_WORD = '0
)(
   input  logic                                      clk,
   input  logic                                      rst,
   input  logic                                      fetch_en,
   output logic [INSTR_ADDR_WIDTH-1:0]               mem_pc,
   input  logic [STEP*8-1:0]                         mem_instr,
   input  logic                                      redirect,
   input  logic [INSTR_ADDR_WIDTH+$clog2(STEP)-1:0]  redirect_addr,
   output logic                                      out_valid,
   input  logic                                      out_ready,
   output logic [STEP*8-1:0]                         out_instr,
   output logic [INSTR_ADDR_WIDTH-1:0]               out_pc,
   output logic                                      out_misalign
);
   localparam int SHIFT = $clog2(STEP);

   fetch_state_t                   state, state_n;
   logic [INSTR_ADDR_WIDTH-1:0]    tag, tgt_word;
   logic [SHIFT-1:0]               tgt_off;
   logic                           inflight, inf_epoch, epoch;
   logic                           halt, mis_pend, push, pop, issue;
   fetch_entry_t                   din, head;
   logic [$clog2(FIFO_DEPTH):0]    count;

   assign {tgt_word, tgt_off} = redirect_addr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Credit counts the slot freed by this cycle's pop so a steady stream issues every clock.
   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (fetch_en)  state_n = RUN;
         RUN:  if (!fetch_en) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      pop   = out_valid && out_ready && !redirect;
      issue = (state_n == RUN) && !redirect && !halt &&
              ((int'(count) + int'(inflight) - int'(pop)) < FIFO_DEPTH);
      push  = (inflight && (inf_epoch == epoch)) || mis_pend;
      din   = '{misalign: mis_pend,
                pc:       mis_pend ? mem_pc : tag,
                instr:    mis_pend ? '0 : mem_instr};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_pc    <= RESET_WORD;
         tag       <= '0;
         inflight  <= 1'b0;
         inf_epoch <= 1'b0;
         epoch     <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            tag       <= mem_pc;
            inf_epoch <= epoch;
         end
         if (redirect) begin
            mem_pc <= tgt_word;
            epoch  <= ~epoch;
         end else if (issue) begin
            mem_pc <= mem_pc + 1'b1;
         end
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   // A misaligned target yields one trap entry, then fetch stays parked until the next redirect.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         halt     <= 1'b0;
         mis_pend <= 1'b0;
      end else begin
         mis_pend <= redirect && (|tgt_off);
         if (redirect) halt <= |tgt_off;
      end
   end
`else
   assign halt     = 1'b0;
   assign mis_pend = 1'b0;
`endif

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (din),
      .pop   (pop),
      .flush (redirect),
      .dout  (head),
      .count (count)
   );

   assign out_valid    = (count != '0);
   assign out_instr    = head.instr;
   assign out_pc       = head.pc;
   assign out_misalign = head.misalign;
endmodule
